archie_kbd_proto: RTL and testbench

//  Keyboard-side protocol engine for the IOC serial keyboard link. Consumes host bytes
//  (KBD_OUT_DATA/STROBE from ioc) and produces keyboard bytes (KBD_IN_DATA/STROBE).

---
 rtl/archie_kbd_proto.sv | 262 ++++++++++++++++++++++++++
 tb/tb_archie_kbd_proto.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/archie_kbd_proto.sv
// Keyboard-side engine for the IOC serial keyboard link: HRST/RAK reset handshake,
// key row/col and mouse dx/dy pairs with BACK/ACK flow control, and host query replies.
module archie_kbd_proto #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [5:0]  KBD_ID     = 6'h01,
    parameter logic [15:0] TX_GAP     = 16'd0,
    parameter logic [23:0] TIMEOUT    = 24'd7000000
) (
    input  logic       clkcpu,
    input  logic       rst_i,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_up,
    output logic       key_ready,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    input  logic [7:0] kbd_out_data,
    input  logic       kbd_out_strobe,
    output logic [7:0] kbd_in_data,
    output logic       kbd_in_strobe,
    output logic [2:0] leds
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_SEND_HRST, S_SYNC1, S_SYNC2, S_IDLE, S_K_BACK, S_K_ACK, S_M_BACK, S_M_ACK
    } state_t;

    typedef enum logic [2:0] {TX_FIX, TX_ROW, TX_COL, TX_DX, TX_DY} txk_t;

    state_t             state_q, state_d;
    logic               rep_pend_q, rep_pend_d;
    txk_t               rep_kind_q, rep_kind_d;
    logic [7:0]         rep_byte_q, rep_byte_d;
    logic [7:0]         out_q, out_d;
    logic [15:0]        gap_q, gap_d;
    logic [2:0]         leds_q, leds_d;
    logic               en_kbd_q, en_kbd_d, en_mouse_q, en_mouse_d;
    logic signed [6:0]  dx_q, dx_d, dy_q, dy_d;
    logic [23:0]        tmo_q, tmo_d;
    logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
    logic [8:0]         mem_q [FIFO_DEPTH];

    logic               send_en, pop, push, flush, err, clr_dx, clr_dy, waiting;
    logic               fifo_empty, fifo_full;
    txk_t               send_kind;
    logic [7:0]         send_fix, send_byte;
    logic [8:0]         head;
    logic signed [6:0]  dx_base, dy_base;

    function automatic logic signed [6:0] sat_add(input logic signed [6:0] base,
                                                  input logic signed [7:0] delta);
        logic signed [8:0] sum;
        sum = {{2{base[6]}}, base} + {delta[7], delta};
        if (sum > 9'sd63)
            return 7'sd63;
        else if (sum < -9'sd64)
            return -7'sd64;
        else
            return sum[6:0];
    endfunction

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head       = mem_q[rd_q[AW-1:0]];
    assign key_ready  = !fifo_full || pop;
    assign push       = key_valid && key_ready;
    assign waiting    = (state_q == S_K_BACK) || (state_q == S_K_ACK) ||
                        (state_q == S_M_BACK) || (state_q == S_M_ACK);

    always_comb begin
        state_d    = state_q;
        rep_pend_d = rep_pend_q;
        rep_kind_d = rep_kind_q;
        rep_byte_d = rep_byte_q;
        out_d      = out_q;
        leds_d     = leds_q;
        en_kbd_d   = en_kbd_q;
        en_mouse_d = en_mouse_q;
        send_en    = 1'b0;
        send_kind  = TX_FIX;
        send_fix   = 8'h00;
        send_byte  = 8'h00;
        pop        = 1'b0;
        flush      = 1'b0;
        err        = 1'b0;
        clr_dx     = 1'b0;
        clr_dy     = 1'b0;

        // A pending reply always goes first; new pairs never start on a host-byte cycle.
        if (gap_q == 16'd0 && !rst_i) begin
            if (rep_pend_q) begin
                send_en    = 1'b1;
                send_kind  = rep_kind_q;
                send_fix   = rep_byte_q;
                rep_pend_d = 1'b0;
            end else if (!kbd_out_strobe) begin
                case (state_q)
                    S_SEND_HRST: begin
                        send_en  = 1'b1;
                        send_fix = 8'hFF;
                        state_d  = S_SYNC1;
                    end
                    S_IDLE: begin
                        if (en_kbd_q && !fifo_empty) begin
                            send_en   = 1'b1;
                            send_kind = TX_ROW;
                            state_d   = S_K_BACK;
                        end else if (en_mouse_q && (dx_q != 7'sd0 || dy_q != 7'sd0)) begin
                            send_en   = 1'b1;
                            send_kind = TX_DX;
                            state_d   = S_M_BACK;
                        end
                    end
                    default: ;
                endcase
            end
        end

        case (send_kind)
            TX_ROW:  send_byte = {3'b110, head[8], head[7:4]};
            TX_COL:  send_byte = {3'b110, head[8], head[3:0]};
            TX_DX:   send_byte = {1'b0, dx_q};
            TX_DY:   send_byte = {1'b0, dy_q};
            default: send_byte = send_fix;
        endcase
        if (send_en) begin
            out_d  = send_byte;
            pop    = (send_kind == TX_COL);
            clr_dx = (send_kind == TX_DX);
            clr_dy = (send_kind == TX_DY);
        end

        if (kbd_out_strobe) begin
            if (kbd_out_data == 8'hFF) begin
                err = 1'b1;
            end else begin
                case (state_q)
                    S_SYNC1: begin
                        if (kbd_out_data == 8'hFE) begin
                            rep_pend_d = 1'b1; rep_kind_d = TX_FIX; rep_byte_d = 8'hFE;
                            state_d    = S_SYNC2;
                        end else err = 1'b1;
                    end
                    S_SYNC2: begin
                        if (kbd_out_data == 8'hFD) begin
                            rep_pend_d = 1'b1; rep_kind_d = TX_FIX; rep_byte_d = 8'hFD;
                            state_d    = S_IDLE;
                        end else err = 1'b1;
                    end
                    S_IDLE: begin
                        casez (kbd_out_data)
                            8'b0000_0???: leds_d = kbd_out_data[2:0];
                            8'h20: begin
                                rep_pend_d = 1'b1; rep_kind_d = TX_FIX;
                                rep_byte_d = {2'b10, KBD_ID};
                            end
                            8'h22: begin
                                rep_pend_d = 1'b1; rep_kind_d = TX_DX;
                                state_d    = S_M_BACK;
                            end
                            8'b0100_????: begin
                                rep_pend_d = 1'b1; rep_kind_d = TX_FIX;
                                rep_byte_d = {4'hE, kbd_out_data[3:0]};
                            end
                            8'b0011_00??: begin
                                en_kbd_d   = kbd_out_data[0];
                                en_mouse_d = kbd_out_data[1];
                            end
                            default: ;
                        endcase
                    end
                    S_K_BACK, S_M_BACK: begin
                        if (kbd_out_data == 8'h3F) begin
                            rep_pend_d = 1'b1;
                            rep_kind_d = (state_q == S_K_BACK) ? TX_COL : TX_DY;
                            state_d    = (state_q == S_K_BACK) ? S_K_ACK : S_M_ACK;
                        end else err = 1'b1;
                    end
                    S_K_ACK, S_M_ACK: begin
                        if (kbd_out_data[7:2] == 6'b0011_00) begin
                            en_kbd_d   = kbd_out_data[0];
                            en_mouse_d = kbd_out_data[1];
                            state_d    = S_IDLE;
                        end else err = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (waiting && !rep_pend_q && tmo_q >= TIMEOUT) begin
            err = 1'b1;
        end

        // Protocol error and host HRST share one recovery path.
        if (err) begin
            flush      = 1'b1;
            rep_pend_d = 1'b1;
            rep_kind_d = TX_FIX;
            rep_byte_d = 8'hFF;
            state_d    = S_SYNC1;
            en_kbd_d   = 1'b0;
            en_mouse_d = 1'b0;
        end
    end

    always_comb begin
        gap_d = kbd_out_strobe ? TX_GAP : ((gap_q != 16'd0) ? gap_q - 16'd1 : gap_q);
        tmo_d = (waiting && !rep_pend_q && !kbd_out_strobe && !err) ? tmo_q + 24'd1 : 24'd0;
        wr_d  = flush ? wr_q : wr_q + {{AW{1'b0}}, push};
        rd_d  = flush ? wr_q : rd_q + {{AW{1'b0}}, pop};
        dx_base = (clr_dx || flush) ? 7'sd0 : dx_q;
        dy_base = (clr_dy || flush) ? 7'sd0 : dy_q;
        dx_d  = mouse_strobe ? sat_add(dx_base, mouse_dx) : dx_base;
        dy_d  = mouse_strobe ? sat_add(dy_base, mouse_dy) : dy_base;
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_q    <= S_SEND_HRST;
            rep_pend_q <= 1'b0;
            rep_kind_q <= TX_FIX;
            rep_byte_q <= 8'h00;
            out_q      <= 8'h00;
            gap_q      <= 16'd0;
            leds_q     <= 3'd0;
            en_kbd_q   <= 1'b0;
            en_mouse_q <= 1'b0;
            dx_q       <= 7'sd0;
            dy_q       <= 7'sd0;
            tmo_q      <= 24'd0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            rep_pend_q <= rep_pend_d;
            rep_kind_q <= rep_kind_d;
            rep_byte_q <= rep_byte_d;
            out_q      <= out_d;
            gap_q      <= gap_d;
            leds_q     <= leds_d;
            en_kbd_q   <= en_kbd_d;
            en_mouse_q <= en_mouse_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            tmo_q      <= tmo_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (push && !flush)
            mem_q[wr_q[AW-1:0]] <= {key_up, key_code};
    end

    assign kbd_in_strobe = send_en;
    assign kbd_in_data   = send_en ? send_byte : out_q;
    assign leds          = leds_q;

endmodule

// File: tb/tb_archie_kbd_proto.sv
// Directed bench: main instance (TX_GAP=0) plus a TX_GAP=4 instance for reply spacing.
module tb_archie_kbd_proto;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, key_up, mouse_strobe, host_stb;
    logic [7:0] key_code, mouse_dx, mouse_dy, host_data;
    logic       kr0, kr1, stb0, stb1;
    logic [7:0] d0, d1;
    logic [2:0] leds0, leds1;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         t_host = 0;
    logic [7:0] q0[$], q1[$];
    int         t0[$], t1[$];
    logic [7:0] sync_b [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    archie_kbd_proto #(.TIMEOUT(24'd100)) u_dut (
        .clkcpu(clk), .rst_i(rst), .key_valid(key_valid), .key_code(key_code),
        .key_up(key_up), .key_ready(kr0), .mouse_strobe(mouse_strobe),
        .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .kbd_out_data(host_data),
        .kbd_out_strobe(host_stb), .kbd_in_data(d0), .kbd_in_strobe(stb0), .leds(leds0));

    archie_kbd_proto #(.TX_GAP(16'd4), .TIMEOUT(24'd100)) u_gap (
        .clkcpu(clk), .rst_i(rst), .key_valid(key_valid), .key_code(key_code),
        .key_up(key_up), .key_ready(kr1), .mouse_strobe(mouse_strobe),
        .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .kbd_out_data(host_data),
        .kbd_out_strobe(host_stb), .kbd_in_data(d1), .kbd_in_strobe(stb1), .leds(leds1));

    always @(negedge clk) begin
        if (stb0) begin q0.push_back(d0); t0.push_back(cyc); end
        if (stb1) begin q1.push_back(d1); t1.push_back(cyc); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q0.delete(); t0.delete(); q1.delete(); t1.delete();
    endtask

    task automatic host_tx(input logic [7:0] b);
        host_data = b; host_stb = 1'b1; t_host = cyc;
        tick(1);
        host_stb = 1'b0;
    endtask

    task automatic push(input logic [7:0] code, input logic up);
        key_code = code; key_up = up; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
    endtask

    // Host byte, then expect n bytes (0 or 1) from the main instance, one cycle later.
    task automatic xact(input string tag, input logic [7:0] hb, input int n, input logic [7:0] e);
        clr();
        host_tx(hb);
        tick(9);
        check({tag, " count"}, q0.size(), n);
        if (q0.size() > 0 && n > 0) begin
            check(tag, {24'd0, q0[0]}, {24'd0, e});
            check({tag, " lat"}, t0[0] - t_host, 1);
        end
    endtask

    task automatic expect1(input string tag, input logic [7:0] e);
        check({tag, " count"}, q0.size(), 1);
        if (q0.size() > 0) check(tag, {24'd0, q0[0]}, {24'd0, e});
        clr();
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_up = 1'b0; key_code = 8'h00;
        mouse_strobe = 1'b0; mouse_dx = 8'h00; mouse_dy = 8'h00;
        host_stb = 1'b0; host_data = 8'h00;
        sync_b = '{8'hFF, 8'hFE, 8'hFD};
        tick(3);
        check("rst strobe", {31'd0, stb0}, 0);
        check("rst data", {24'd0, d0}, 0);
        check("rst leds", {29'd0, leds0}, 0);
        check("rst key_ready", {31'd0, kr0}, 1);

        clr();
        rst = 1'b0;
        tick(4);
        expect1("post-rst hrst", 8'hFF);

        // Handshake on both instances: reply spacing 1 cycle vs TX_GAP+1.
        for (int i = 0; i < 3; i++) begin
            clr();
            host_tx(sync_b[i]);
            tick(9);
            check("sync count", q0.size(), 1);
            check("gap count", q1.size(), 1);
            if (q0.size() > 0) begin
                check("sync byte", {24'd0, q0[0]}, {24'd0, sync_b[i]});
                check("sync lat", t0[0] - t_host, 1);
            end
            if (q1.size() > 0) begin
                check("gap byte", {24'd0, q1[0]}, {24'd0, sync_b[i]});
                check("gap lat", t1[0] - t_host, 5);
            end
        end
        clr(); tick(10);
        check("idle quiet", q0.size(), 0);

        // Key pair with flow control.
        xact("smak", 8'h33, 0, 8'h00);
        clr(); push(8'h5A, 1'b0); tick(5);
        expect1("key row", 8'hC5);
        xact("key col", 8'h3F, 1, 8'hCA);
        xact("key sack", 8'h31, 0, 8'h00);

        // Mouse accumulates while disabled; dx saturates at +63.
        clr();
        mouse_dx = 8'd100; mouse_dy = 8'hFD; mouse_strobe = 1'b1;
        tick(1);
        mouse_strobe = 1'b0;
        tick(9);
        check("mouse disabled", q0.size(), 0);
        xact("mouse dx", 8'h33, 1, 8'h3F);
        xact("mouse dy", 8'h3F, 1, 8'h7D);
        xact("mouse ack", 8'h33, 0, 8'h00);
        xact("rqmp dx", 8'h22, 1, 8'h00);
        xact("rqmp dy", 8'h3F, 1, 8'h00);
        xact("nack", 8'h30, 0, 8'h00);

        // Keys queue while disabled; FIFO fills at 8.
        clr();
        push(8'h12, 1'b0); push(8'h34, 1'b1); push(8'h56, 1'b0);
        tick(9);
        check("nack quiet", q0.size(), 0);
        xact("sack row", 8'h31, 1, 8'hC1);
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
        check("seven ready", {31'd0, kr0}, 1);
        push(8'h05, 1'b0);
        check("full ready", {31'd0, kr0}, 0);
        xact("full col", 8'h3F, 1, 8'hC2);
        check("pop ready", {31'd0, kr0}, 1);
        xact("next row up", 8'h31, 1, 8'hD3);
        xact("hrst mid", 8'hFF, 1, 8'hFF);
        xact("resync fe", 8'hFE, 1, 8'hFE);
        xact("resync fd", 8'hFD, 1, 8'hFD);
        xact("flushed", 8'h31, 0, 8'h00);

        // Timeout waiting for ACK.
        clr(); push(8'h77, 1'b0); tick(5);
        expect1("to row", 8'hC7);
        xact("to col", 8'h3F, 1, 8'hC7);
        clr();
        for (int i = 0; i < 200 && q0.size() == 0; i++) tick(1);
        check("to count", q0.size(), 1);
        if (q0.size() > 0) begin
            check("to byte", {24'd0, q0[0]}, 32'hFF);
            check("to lat", {31'd0, (t0[0] - t_host >= 100) && (t0[0] - t_host <= 110)}, 1);
        end

        // Unexpected byte in SYNC1, then host commands in IDLE.
        xact("sync1 junk", 8'h20, 1, 8'hFF);
        xact("sync fe", 8'hFE, 1, 8'hFE);
        xact("sync fd", 8'hFD, 1, 8'hFD);
        xact("leds cmd", 8'h05, 0, 8'h00);
        check("leds 5", {29'd0, leds0}, 5);
        xact("rqid", 8'h20, 1, 8'h81);
        xact("rqpd", 8'h43, 1, 8'hE3);
        xact("idle bk", 8'h3F, 0, 8'h00);
        xact("idle 21", 8'h21, 0, 8'h00);
        xact("leds cmd2", 8'h02, 0, 8'h00);
        check("leds 2", {29'd0, leds0}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
